// File: rtl/cpu_oci_dct_capture_pkg.sv
// rtl/cpu_oci_dct_capture_pkg.sv - shared types and constants for the DCT capture buffer
package cpu_oci_dct_pkg;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_FROZEN  = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } dct_state_e;

    localparam bit DCT_MODE_DROP = 1'b0;
    localparam bit DCT_MODE_WRAP = 1'b1;

endpackage

// File: rtl/cpu_oci_dct_capture_if.sv
// rtl/cpu_oci_dct_capture_if.sv - capture, control and drain signals of the DCT buffer
interface cpu_oci_dct_capture_if #(
    parameter int DATA_W = 30,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              dct_valid;
    logic [DATA_W-1:0] dct_word;
    logic              test_ending;
    logic              test_has_ended;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;
    logic [CNT_W-1:0]  dct_count;
    logic              overflow;
    logic              capturing;
    logic              drain_done;

    modport master (
        output dct_valid, dct_word, test_ending, test_has_ended, rd_ready,
        input  rd_valid, rd_data, dct_count, overflow, capturing, drain_done
    );

    modport slave (
        input  dct_valid, dct_word, test_ending, test_has_ended, rd_ready,
        output rd_valid, rd_data, dct_count, overflow, capturing, drain_done
    );

endinterface

// File: rtl/cpu_oci_dct_ram.sv
// rtl/cpu_oci_dct_ram.sv - register array with one write port and one asynchronous read port
module cpu_oci_dct_ram #(
    parameter int DATA_W = 30,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_oci_dct_capture.sv
// rtl/cpu_oci_dct_capture.sv - circular DCT capture store with freeze and oldest-first drain
module cpu_oci_dct_capture
    import cpu_oci_dct_pkg::*;
#(
    parameter int DATA_W    = 30,
    parameter int DEPTH     = 16,
    parameter bit WRAP_MODE = DCT_MODE_WRAP
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_oci_dct_capture_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    dct_state_e        r_state;
    dct_state_e        w_next_state;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic              w_full;
    logic              w_empty;
    logic              w_cap_valid;
    logic              w_we;
    logic              w_rd_valid;
    logic              w_hs;
    logic [DATA_W-1:0] w_rdata;

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_cap_valid = (r_state == ST_CAPTURE) && bus.dct_valid;
    assign w_we        = w_cap_valid && (!w_full || (WRAP_MODE == DCT_MODE_WRAP));
    assign w_rd_valid  = (r_state == ST_DRAIN) && !w_empty;
    assign w_hs        = w_rd_valid && bus.rd_ready;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_CAPTURE: begin
                if (bus.test_has_ended) begin
                    w_next_state = ST_DRAIN;
                end else if (bus.test_ending) begin
                    w_next_state = ST_FROZEN;
                end
            end
            ST_FROZEN: begin
                if (bus.test_has_ended) begin
                    w_next_state = ST_DRAIN;
                end
            end
            // Exit is judged on the registered count, so the last beat is followed by one idle DRAIN cycle.
            ST_DRAIN: begin
                if (w_empty) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE:  w_next_state = ST_DONE;
            default:  w_next_state = ST_CAPTURE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_CAPTURE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            // A wrapping write over a full store discards the oldest entry.
            if (w_hs || (w_we && w_full)) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_cap_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_we && !w_full) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_hs) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    cpu_oci_dct_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.dct_word),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign bus.rd_valid   = w_rd_valid;
    assign bus.rd_data    = w_rd_valid ? w_rdata : '0;
    assign bus.dct_count  = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.capturing  = (r_state == ST_CAPTURE);
    assign bus.drain_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_cpu_oci_dct_capture.sv
// tb/tb_cpu_oci_dct_capture.sv - scoreboard bench driving a wrap-mode and a drop-mode buffer in lockstep
module tb_cpu_oci_dct_capture;
    import cpu_oci_dct_pkg::*;

    localparam int DATA_W = 30;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              dct_valid;
    logic [DATA_W-1:0] dct_word;
    logic              test_ending;
    logic              test_has_ended;
    logic              rd_ready;

    always #5 clk = ~clk;

    cpu_oci_dct_capture_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) if_w ();
    cpu_oci_dct_capture_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) if_d ();

    assign if_w.dct_valid      = dct_valid;
    assign if_w.dct_word       = dct_word;
    assign if_w.test_ending    = test_ending;
    assign if_w.test_has_ended = test_has_ended;
    assign if_w.rd_ready       = rd_ready;
    assign if_d.dct_valid      = dct_valid;
    assign if_d.dct_word       = dct_word;
    assign if_d.test_ending    = test_ending;
    assign if_d.test_has_ended = test_has_ended;
    assign if_d.rd_ready       = rd_ready;

    cpu_oci_dct_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WRAP_MODE(DCT_MODE_WRAP)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (if_w)
    );

    cpu_oci_dct_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WRAP_MODE(DCT_MODE_DROP)) u_drop (
        .clk   (clk),
        .reset (reset),
        .bus   (if_d)
    );

    // Index 0 is the wrap-mode instance, index 1 the drop-mode instance.
    logic              rv   [2];
    logic [DATA_W-1:0] rdat [2];
    logic [CNT_W-1:0]  cnt  [2];
    logic              ovf  [2];
    logic              cap  [2];
    logic              done [2];

    assign rv[0] = if_w.rd_valid;   assign rv[1] = if_d.rd_valid;
    assign rdat[0] = if_w.rd_data;  assign rdat[1] = if_d.rd_data;
    assign cnt[0] = if_w.dct_count; assign cnt[1] = if_d.dct_count;
    assign ovf[0] = if_w.overflow;  assign ovf[1] = if_d.overflow;
    assign cap[0] = if_w.capturing; assign cap[1] = if_d.capturing;
    assign done[0] = if_w.drain_done; assign done[1] = if_d.drain_done;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mq  [2][$];
    logic [DATA_W-1:0] sbq [2][$];
    bit                movf [2];
    int                mstate;
    int                cyc = 0;
    int                req_cyc = 0;
    int                last_hs [2];
    bit                stalled [2];
    logic [DATA_W-1:0] stall_data [2];
    bit                prev_done [2];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h at cycle %0d", nm, k, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                for (int k = 0; k < 2; k++) begin
                    stalled[k]   = 1'b0;
                    prev_done[k] = 1'b0;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (stalled[k]) begin
                        chk("stall_valid", k, 32'(rv[k]), 32'd1);
                        chk("stall_data", k, 32'(rdat[k]), 32'(stall_data[k]));
                    end
                    if (rv[k] && rd_ready) begin
                        checks++;
                        if (sbq[k].size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_word[%0d]: got %0h expected no word at cycle %0d", k, rdat[k], cyc);
                        end else begin
                            logic [DATA_W-1:0] e;
                            e = sbq[k].pop_front();
                            if (rdat[k] !== e) begin
                                errors++;
                                $display("FAIL drain_word[%0d]: got %0h expected %0h at cycle %0d", k, rdat[k], e, cyc);
                            end
                        end
                        last_hs[k] = cyc;
                    end
                    stalled[k]    = rv[k] && !rd_ready;
                    stall_data[k] = rdat[k];
                    if (done[k] && !prev_done[k]) begin
                        chk("done_latency", k, 32'(cyc), 32'(((last_hs[k] > req_cyc) ? last_hs[k] : req_cyc) + 2));
                    end
                    prev_done[k] = done[k];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(input logic [DATA_W-1:0] w);
        for (int k = 0; k < 2; k++) begin
            if (mq[k].size() < DEPTH) begin
                mq[k].push_back(w);
            end else begin
                movf[k] = 1'b1;
                if (k == 0) begin
                    void'(mq[k].pop_front());
                    mq[k].push_back(w);
                end
            end
        end
    endtask

    task automatic start_drain();
        for (int k = 0; k < 2; k++) begin
            sbq[k] = mq[k];
            mq[k].delete();
            last_hs[k] = -1;
        end
        mstate  = 2;
        req_cyc = cyc + 1;
    endtask

    task automatic drive(input bit v, input logic [DATA_W-1:0] w, input bit te, input bit th);
        dct_valid      = v;
        dct_word       = w;
        test_ending    = te;
        test_has_ended = th;
        if (mstate == 0) begin
            if (v) model_push(w);
            if (th) start_drain();
            else if (te) mstate = 1;
        end else if (mstate == 1) begin
            if (th) start_drain();
        end
        tick();
        dct_valid      = 1'b0;
        dct_word       = '0;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rd_ready = 1'b0;
        dct_valid = 1'b0; dct_word = '0; test_ending = 1'b0; test_has_ended = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            sbq[k].delete();
            movf[k] = 1'b0;
            last_hs[k] = -1;
            chk("rst_capturing", k, 32'(cap[k]), 32'd1);
            chk("rst_done", k, 32'(done[k]), 32'd0);
            chk("rst_rd_valid", k, 32'(rv[k]), 32'd0);
            chk("rst_rd_data", k, 32'(rdat[k]), 32'd0);
            chk("rst_count", k, 32'(cnt[k]), 32'd0);
            chk("rst_overflow", k, 32'(ovf[k]), 32'd0);
        end
        mstate = 0;
        reset = 1'b0;
    endtask

    task automatic check_fill();
        for (int k = 0; k < 2; k++) begin
            chk("fill_count", k, 32'(cnt[k]), 32'(mq[k].size()));
            chk("fill_overflow", k, 32'(ovf[k]), 32'(movf[k]));
        end
    endtask

    task automatic drain(input int mode);
        int i;
        i = 0;
        while (!(done[0] && done[1]) && i < 200) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (i % 2 == 0);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            i++;
        end
        rd_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("drain_finished", k, 32'(done[k]), 32'd1);
            chk("sb_empty", k, 32'(sbq[k].size()), 32'd0);
            chk("end_count", k, 32'(cnt[k]), 32'd0);
            chk("end_rd_valid", k, 32'(rv[k]), 32'd0);
            chk("end_overflow", k, 32'(ovf[k]), 32'(movf[k]));
        end
    endtask

    initial begin
        reset = 1'b1;
        rd_ready = 1'b0;
        dct_valid = 1'b0; dct_word = '0; test_ending = 1'b0; test_has_ended = 1'b0;
        mstate = 0;
        for (int k = 0; k < 2; k++) begin
            last_hs[k] = -1; stalled[k] = 1'b0; prev_done[k] = 1'b0; movf[k] = 1'b0;
        end
        tick();

        do_reset();
        for (int i = 1; i <= 5; i++) drive(1'b1, DATA_W'(i), 1'b0, 1'b0);
        check_fill();
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);
        drain(0);

        do_reset();
        for (int i = 0; i < 20; i++) drive(1'b1, DATA_W'(i), 1'b0, 1'b0);
        check_fill();
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);
        drain(0);

        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);
        drain(1);

        do_reset();
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        check_fill();
        drive(1'b0, '0, 1'b0, 1'b1);
        drain(0);

        do_reset();
        for (int i = 0; i < 9; i++) drive(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        drive(1'b1, DATA_W'($urandom), 1'b0, 1'b1);
        begin
            int n;
            n = 0;
            rd_ready = 1'b1;
            while (cnt[0] != CNT_W'(6) && n < 40) begin
                tick();
                n++;
            end
            chk("mid_reach6", 0, 32'(cnt[0]), 32'd6);
            rd_ready = 1'b0;
            reset = 1'b1;
            tick();
            for (int k = 0; k < 2; k++) begin
                chk("mid_rst_count", k, 32'(cnt[k]), 32'd0);
                chk("mid_rst_capturing", k, 32'(cap[k]), 32'd1);
                chk("mid_rst_rd_valid", k, 32'(rv[k]), 32'd0);
                sbq[k].delete();
            end
            reset = 1'b0;
            mstate = 0;
        end

        for (int it = 0; it < 8; it++) begin
            int nw;
            bit direct;
            do_reset();
            nw = $urandom_range(0, 24);
            direct = 1'($urandom_range(0, 1));
            for (int i = 0; i < nw; i++) begin
                if ($urandom_range(0, 3) == 0) drive(1'b0, '0, 1'b0, 1'b0);
                drive(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
            end
            check_fill();
            if (direct) begin
                drive(1'($urandom_range(0, 1)), DATA_W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            end else begin
                drive(1'($urandom_range(0, 1)), DATA_W'($urandom), 1'b1, 1'b0);
                for (int i = 0; i < 3; i++) drive(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
                check_fill();
                drive(1'b0, '0, 1'b0, 1'b1);
            end
            drain($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_oci_dct_capture.md
# cpu_oci_dct_capture

Parametrised data-capture-trace (DCT) buffer for the CPU on-chip instrumentation block. Captures DCT words emitted by the OCI during simulation or debug into a circular store and keeps a live word count. On a test-ending request it freezes the store. After test end it drains the captured words oldest-first over a valid/ready port for the bench or JTAG readback path.

## Interface
- `DATA_W`, 30, DCT word width
- `DEPTH`, 16, buffer entries; power of two, ≥ 2
- `WRAP_MODE`, 1, 1 = overwrite oldest when full, 0 = drop new words when full
- `CNT_W`, $clog2(DEPTH+1), count width (derived, not overridable)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `dct_valid`  in  1  DCT word present this cycle
- `dct_word`  in  DATA_W  DCT word
- `test_ending`  in  1  request to freeze capture (level or pulse)
- `test_has_ended`  in  1  request to start drain (level or pulse)
- `rd_valid`  out  1  drain word available
- `rd_data`  out  DATA_W  oldest unread word
- `rd_ready`  in  1  consumer accepts `rd_data`
- `dct_count`  out  CNT_W  words currently held
- `overflow`  out  1  sticky: at least one word lost or overwritten
- `capturing`  out  1  high in CAPTURE state
- `drain_done`  out  1  high in DONE state

## Operation
- States: CAPTURE → FROZEN → DRAIN → DONE.
- CAPTURE:
  - `dct_valid` writes `dct_word` at `wr_ptr`, then `wr_ptr`++ mod DEPTH and count++.
  - When full and WRAP_MODE=1, the write still happens. `rd_ptr` advances, count holds at DEPTH, and `overflow` is set.
  - When full and WRAP_MODE=0, the word is dropped. Pointers and count hold, and `overflow` is set.
- CAPTURE → FROZEN on `test_ending`. A `dct_valid` in the same cycle is still captured.
- CAPTURE → DRAIN directly on `test_has_ended`, whatever the state of `test_ending`. A same-cycle `dct_valid` is captured.
- FROZEN: `dct_valid` is ignored and does not set `overflow`. FROZEN → DRAIN on `test_has_ended`.
- DRAIN:
  - `rd_valid` = (count ≠ 0) and `rd_data` = mem[`rd_ptr`].
  - Handshake `rd_valid && rd_ready`: `rd_ptr`++ mod DEPTH and count--.
  - DRAIN → DONE when count is 0 at the start of a cycle. This includes entering DRAIN with an empty buffer.
- DONE: all inputs except `reset` are ignored. The block stays in DONE until `reset`.
- `test_ending` and `test_has_ended` are ignored outside the transitions listed above.

## Timing
- Reset values: state CAPTURE, `capturing`=1, `drain_done`=0, `rd_valid`=0, `rd_data`=0, `dct_count`=0, `overflow`=0. Both pointers reset to 0.
- `reset` mid-drain takes effect at the next edge. Buffer contents become don't-care and the count clears.
- A write in cycle N is reflected in `dct_count` at N+1.
- State changes are registered. Requests in cycle N give the new state at N+1, and `rd_valid` may first be high at N+1 after `test_has_ended`.
- `rd_data` is combinational from the array at `rd_ptr`. It is stable while `rd_valid && !rd_ready`.
- `rd_valid` must not drop without a handshake. One word can be accepted per cycle, so back-to-back drain runs at full rate.
- `rd_valid` is low in the cycle after the last handshake. `drain_done` rises one cycle after that.
- `dct_count` never exceeds DEPTH. `overflow` clears only on `reset`.

## Structure
- Package `cpu_oci_dct_pkg` holds:
  - the state enum (CAPTURE, FROZEN, DRAIN, DONE), 2 bits;
  - the mode constants `DCT_MODE_DROP`=0 and `DCT_MODE_WRAP`=1.
- One sub-module, `cpu_oci_dct_ram`: a DEPTH×DATA_W register array with one write port and one asynchronous read port.
- The top level holds the FSM, the pointers, the count and the overflow logic.

## Test plan
- Reset, then 5 words 0x1..0x5, `test_ending`, then `test_has_ended` with `rd_ready`=1 → `dct_count` 5→0, `rd_data` 0x1..0x5 on consecutive cycles, `drain_done` two cycles after the last beat, `overflow`=0.
- WRAP_MODE=1, DEPTH=16, 20 words 0..19 → `dct_count`=16, `overflow`=1, drain yields 4..19.
- WRAP_MODE=0, 20 words 0..19 → drain yields 0..15, `overflow`=1.
- `rd_ready` toggled 1/0 during drain of 3 words → `rd_data` held while stalled, all 3 words delivered in order, no duplicates.
- After `test_ending`, 4 more `dct_valid` pulses → count unchanged and `overflow`=0. `test_has_ended` on an empty buffer → DONE after 2 cycles with `rd_valid` never high.
- `reset` asserted mid-drain with 6 words left → next cycle `dct_count`=0, `capturing`=1, `rd_valid`=0.
